branch_ctrl_seq: RTL

// - Control-step sequencer for conditional-branch instructions (brzr/brnz/brpl/brmi). Drives the

---
 rtl/branch_ctrl_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/branch_ctrl_seq.sv
// rtl/branch_ctrl_seq.sv - T3..T6 control-step sequencer for conditional branches
// Optional per-outcome statistics counters when BRANCH_STATS_EN is defined.
module branch_ctrl_seq #(
   parameter logic [4:0] BR_OPCODE = 5'b10010,
   parameter int         CNT_W     = 16
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [31:0]      ir,
   input  logic             con_q,
   output logic             busy,
   output logic             done,
   output logic             bad_op,
   output logic             taken,
   output logic [1:0]       c2_field,
   output logic             gra,
   output logic             r_out,
   output logic             con_in,
   output logic             pc_out,
   output logic             y_in,
   output logic             c_out,
   output logic             alu_add,
   output logic             z_in,
   output logic             zlow_out,
`ifdef BRANCH_STATS_EN
   output logic             pc_in,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] not_taken_cnt
`else
   output logic             pc_in
`endif
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      T3   = 3'd1,
      T4   = 3'd2,
      T5   = 3'd3,
      T6   = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t state;
   state_t state_nx;
   logic   op_ok;
   logic   accept;
   logic   unused_ir;

   assign op_ok     = (ir[31:27] == BR_OPCODE);
   assign accept    = (state == IDLE) && start && op_ok;
   assign unused_ir = ^{ir[26:21], ir[18:0]};

   always_ff @(posedge clock) begin
      if (!clear) begin
         state    <= IDLE;
         taken    <= 1'b0;
         c2_field <= 2'b00;
         bad_op   <= 1'b0;
      end else begin
         state  <= state_nx;
         bad_op <= (state == IDLE) && start && !op_ok;
         if (accept) begin
            taken    <= 1'b0;
            c2_field <= ir[20:19];
         end else if (state == T3) begin
            // con_q is only meaningful while con_in is asserted
            taken <= con_q;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = accept ? T3 : IDLE;
         T3:      state_nx = T4;
         T4:      state_nx = T5;
         T5:      state_nx = T6;
         T6:      state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      gra      = 1'b0;
      r_out    = 1'b0;
      con_in   = 1'b0;
      pc_out   = 1'b0;
      y_in     = 1'b0;
      c_out    = 1'b0;
      alu_add  = 1'b0;
      z_in     = 1'b0;
      zlow_out = 1'b0;
      pc_in    = 1'b0;
      case (state)
         T3: begin
            busy   = 1'b1;
            gra    = 1'b1;
            r_out  = 1'b1;
            con_in = 1'b1;
         end
         T4: begin
            busy   = 1'b1;
            pc_out = 1'b1;
            y_in   = 1'b1;
         end
         T5: begin
            busy    = 1'b1;
            c_out   = 1'b1;
            alu_add = 1'b1;
            z_in    = 1'b1;
         end
         T6: begin
            busy     = 1'b1;
            zlow_out = 1'b1;
            pc_in    = taken;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef BRANCH_STATS_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clock) begin
      if (!clear) begin
         taken_cnt     <= '0;
         not_taken_cnt <= '0;
      end else if (state == T6) begin
         // counters saturate rather than wrap
         if (taken && (taken_cnt != '1))
            taken_cnt <= taken_cnt + CNT_ONE;
         if (!taken && (not_taken_cnt != '1))
            not_taken_cnt <= not_taken_cnt + CNT_ONE;
      end
   end
`else
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_cnt_w = '0;
`endif

endmodule
